// File: rtl/button_op_scheduler.sv
// button_op_scheduler: four debounced buttons arbitrated round-robin onto one shared LED counter.
// Each accepted press becomes a pending request; one request is served per GRANT, followed by a cooldown.
module button_op_scheduler #(
  parameter int CNT_W        = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int COOLDOWN_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       btn,
  input  logic [CNT_W-1:0] sw,
  output logic [CNT_W-1:0] led,
  output logic [3:0]       grant,
  output logic             busy,
  output logic             dropped
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int CW = $clog2(COOLDOWN_CYC + 1);
  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;
  state_t        state;
  logic [3:0]    sync1, sync2, stable, stable_d, pending, rise, clr;
  logic [DW-1:0] db_cnt [4];
  logic [CW-1:0] cd;
  logic [1:0]    rr, win;
  assign rise = stable & ~stable_d;
  assign clr  = (state == GRANT) ? grant : 4'b0;
  // scan downward so the nearest pending index at or after rr wins
  always_comb begin
    win = rr;
    for (int k = 3; k >= 0; k--)
      if (pending[rr + 2'(k)]) win = rr + 2'(k);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 4; i++)
        if (sync2[i] == stable[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
    end
  end
  // a new press wins over the grant clearing the same request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      dropped <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | rise;
      dropped <= dropped | (|(rise & pending & ~clr));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      rr    <= '0;
      cd    <= '0;
      led   <= '0;
    end else begin
      case (state)
        IDLE: if (|pending) begin
          state <= GRANT;
          grant <= 4'b1 << win;
          busy  <= 1'b1;
          rr    <= win + 2'd1;
        end
        GRANT: begin
          state <= COOLDOWN;
          grant <= '0;
          cd    <= '0;
          led   <= grant[0] ? led + 1'b1 : grant[1] ? led - 1'b1 : grant[2] ? '0 : sw;
        end
        COOLDOWN: if (cd == CW'(COOLDOWN_CYC - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else cd <= cd + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_button_op_scheduler.sv
// tb_button_op_scheduler: directed stimulus with a grant/led scoreboard for button_op_scheduler.
module tb_button_op_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn, sw, led, grant;
  logic       busy, dropped;
  typedef struct {logic [3:0] g; logic [3:0] l;} exp_t;
  exp_t sbq[$];
  int   gt[$];
  int   tests = 0, fails = 0, cyc = 0;
  logic [3:0] m_led = '0;
  logic [3:0] exp_led;
  bit   chk_led = 0;
  button_op_scheduler #(.CNT_W(4), .DEBOUNCE_CYC(4), .COOLDOWN_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw),
    .led(led), .grant(grant), .busy(busy), .dropped(dropped)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // reference model of one served operation, updating the expected led
  task automatic expect_op(input int i);
    m_led = (i == 0) ? m_led + 4'd1 : (i == 1) ? m_led - 4'd1 : (i == 2) ? 4'd0 : sw;
    sbq.push_back('{4'(1 << i), m_led});
  endtask
  task automatic press(input logic [3:0] m, input int hold, input int wait_c);
    @(negedge clk);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (wait_c) @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (chk_led) begin
      check("led_after_grant", led, exp_led);
      chk_led = 0;
    end
    if (grant != 0) begin
      gt.push_back(cyc);
      if (sbq.size() == 0) check("unexpected_grant", grant, 0);
      else begin
        e = sbq.pop_front();
        check("grant_onehot", grant, e.g);
        exp_led = e.l;
        chk_led = 1;
      end
    end
  end
  initial begin
    int bc;
    bit seen;
    rst_n = 1'b0;
    btn = '0;
    sw = '0;
    repeat (3) @(negedge clk);
    check("rst_led", led, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    rst_n = 1'b1;
    // 1: clean inc press, busy for GRANT + 2 cooldown cycles
    expect_op(0);
    bc = 0;
    btn = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 10) btn = '0;
      bc += busy;
    end
    check("t1_busy_cycles", bc, 3);
    check("t1_led", led, 1);
    check("t1_sbq_empty", sbq.size(), 0);
    // 2: 3-cycle glitch is filtered
    gt.delete();
    press(4'b0001, 3, 30);
    check("t2_no_grant", gt.size(), 0);
    check("t2_led", led, m_led);
    // 3: clear, dec wraps to 15, load 15, inc wraps to 0, load 0 leaves rr=0
    expect_op(2); press(4'b0100, 6, 25);
    expect_op(1); press(4'b0010, 6, 25);
    check("t3_dec_wrap", led, 15);
    sw = 4'd15;
    expect_op(3); press(4'b1000, 6, 25);
    expect_op(0); press(4'b0001, 6, 25);
    check("t3_inc_wrap", led, 0);
    sw = 4'd0;
    expect_op(3); press(4'b1000, 6, 25);
    check("t3_sbq_empty", sbq.size(), 0);
    // 4: all four at once from rr=0, served 0,1,2,3 four cycles apart
    sw = 4'd9;
    gt.delete();
    expect_op(0); expect_op(1); expect_op(2); expect_op(3);
    press(4'b1111, 8, 40);
    check("t4_ngrants", gt.size(), 4);
    for (int k = 1; k < 4; k++) check("t4_spacing", gt[k] - gt[k-1], 4);
    check("t4_led", led, 9);
    check("t4_sbq_empty", sbq.size(), 0);
    // 5: dec moves rr to 2, then 3 beats 0
    expect_op(1); press(4'b0010, 6, 25);
    expect_op(3); expect_op(0);
    press(4'b1001, 6, 30);
    check("t5_led", led, 10);
    check("t5_sbq_empty", sbq.size(), 0);
    check("t5_no_drop", dropped, 0);
    // 6: btn0 re-pressed while its request waits behind 1,2,3
    sw = 4'd5;
    expect_op(1); expect_op(2); expect_op(3); expect_op(0);
    @(negedge clk);
    btn = 4'b1111;
    repeat (4) @(negedge clk);
    btn = 4'b1110;
    repeat (4) @(negedge clk);
    btn = 4'b1111;
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (30) @(negedge clk);
    check("t6_dropped", dropped, 1);
    check("t6_led_one_inc", led, 6);
    check("t6_sbq_empty", sbq.size(), 0);
    // reset during cooldown with btn0 still pending
    expect_op(1);
    @(negedge clk);
    btn = 4'b0011;
    repeat (5) @(negedge clk);
    btn = '0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = (grant != 0);
    end
    check("t6_grant_seen", seen, 1);
    @(negedge clk);
    check("t6_busy_cooldown", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_led", led, 0);
    check("t6_async_grant", grant, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_dropped", dropped, 0);
    m_led = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gt.delete();
    repeat (30) @(negedge clk);
    check("t6_pending_lost", gt.size(), 0);
    check("t6_led_after", led, 0);
    check("t6_sbq_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
